// File: rtl/isqrt_arb_2_if.sv
// Handshake bundle between two isqrt clients, the arbiter and the shared isqrt.
// slave: the arbiter's view; master: the clients' and the isqrt unit's view.
interface isqrt_arb_2_if;
   logic        c0_x_vld;
   logic [31:0] c0_x;
   logic        c0_x_rdy;
   logic        c0_y_vld;
   logic [15:0] c0_y;
   logic        c1_x_vld;
   logic [31:0] c1_x;
   logic        c1_x_rdy;
   logic        c1_y_vld;
   logic [15:0] c1_y;
   logic        isqrt_x_vld;
   logic [31:0] isqrt_x;
   logic        isqrt_y_vld;
   logic [15:0] isqrt_y;

   modport slave (
      input  c0_x_vld, c0_x, c1_x_vld, c1_x,
      input  isqrt_y_vld, isqrt_y,
      output c0_x_rdy, c0_y_vld, c0_y,
      output c1_x_rdy, c1_y_vld, c1_y,
      output isqrt_x_vld, isqrt_x
   );

   modport master (
      output c0_x_vld, c0_x, c1_x_vld, c1_x,
      output isqrt_y_vld, isqrt_y,
      input  c0_x_rdy, c0_y_vld, c0_y,
      input  c1_x_rdy, c1_y_vld, c1_y,
      input  isqrt_x_vld, isqrt_x
   );
endinterface

// File: rtl/isqrt_arb_2.sv
// Two-client round-robin arbiter in front of one in-order shared isqrt.
// Ports: clk, rst (sync, high), bus (isqrt_arb_2_if.slave), in_flight, err.
module isqrt_arb_2 #(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   isqrt_arb_2_if.slave            bus,
   output logic [$clog2(DEPTH):0]  in_flight,
   output logic                    err
);
   localparam int AW  = $clog2(DEPTH);
   localparam int IFW = AW + 1;

   logic           last_grant_q, last_grant_d;
   logic [IFW-1:0] in_flight_q, in_flight_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic           err_q, err_d;
   logic           tag_q [DEPTH];

   logic full, empty;
   logic gnt0, gnt1;
   logic push, pop, head;

   always_comb begin
      full  = (in_flight_q == IFW'(DEPTH));
      empty = (in_flight_q == '0);
      // On a tie the client not granted last wins.
      gnt0  = !rst && !full && bus.c0_x_vld &&
              (!bus.c1_x_vld || last_grant_q);
      gnt1  = !rst && !full && bus.c1_x_vld &&
              (!bus.c0_x_vld || !last_grant_q);
      push  = gnt0 || gnt1;
      pop   = !rst && bus.isqrt_y_vld && !empty;
      head  = tag_q[rd_ptr_q];
   end

   always_comb begin
      bus.c0_x_rdy    = gnt0;
      bus.c1_x_rdy    = gnt1;
      bus.isqrt_x_vld = push;
      bus.isqrt_x     = '0;
      if (gnt0) bus.isqrt_x = bus.c0_x;
      if (gnt1) bus.isqrt_x = bus.c1_x;
      bus.c0_y_vld    = pop && !head;
      bus.c1_y_vld    = pop && head;
      bus.c0_y        = bus.c0_y_vld ? bus.isqrt_y : '0;
      bus.c1_y        = bus.c1_y_vld ? bus.isqrt_y : '0;
      in_flight       = rst ? '0 : in_flight_q;
      err             = rst ? 1'b0 : err_q;
   end

   always_comb begin
      last_grant_d = last_grant_q;
      in_flight_d  = in_flight_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      // A result with nothing outstanding is a protocol error.
      err_d        = err_q || (bus.isqrt_y_vld && empty);
      if (push) begin
         last_grant_d = gnt1;
         wr_ptr_d     = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   in_flight_d = in_flight_q + IFW'(1);
         2'b01:   in_flight_d = in_flight_q - IFW'(1);
         default: in_flight_d = in_flight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         in_flight_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         in_flight_q  <= in_flight_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         err_q        <= err_d;
      end
   end

   // Tag storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) tag_q[wr_ptr_q] <= gnt1;
   end
endmodule

// File: tb/tb_isqrt_arb_2.sv
// Bench for isqrt_arb_2: random clients and a fixed-latency isqrt model,
// checked each cycle against a queue-based reference of the arbiter.
module tb_isqrt_arb_2;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   isqrt_arb_2_if b ();
   logic [3:0] in_flight;
   logic       err;

   isqrt_arb_2 #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (b),
      .in_flight (in_flight),
      .err       (err)
   );

   typedef struct {
      int          t;
      logic [31:0] x;
   } pend_t;

   pend_t       iq[$];
   bit          tagq[$];
   int          eq0[$];
   int          eq1[$];
   int          gnt_log[$];
   int          res_id[$];
   int          res_y[$];

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          lat = 3;
   bit          c_vld [2];
   logic [31:0] c_x [2];
   int          prob [2];
   bit          m_last = 1'b1;
   bit          m_err = 1'b0;
   bit          spur = 1'b0;

   bit          cap_rdy [2];
   bit          cap_yv [2];
   bit          cap_xv;
   logic [31:0] cap_x;
   int          cap_if;
   bit          cap_err;
   bit          rdy_hist [14];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d cycle=%0d",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic int qget(int q[$], int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   function automatic int ref_sqrt(logic [31:0] x);
      longint r, t;
      r = 0;
      for (int bb = 15; bb >= 0; bb--) begin
         t = r | (64'(1) << bb);
         if (t * t <= longint'(x)) r = t;
      end
      return int'(r);
   endfunction

   task automatic step();
      bit yv, g0, g1, pop, head, full, empty, ev0, ev1;
      logic [15:0] yd;
      logic [31:0] ex;
      int id;
      b.c0_x_vld = c_vld[0];
      b.c0_x     = c_x[0];
      b.c1_x_vld = c_vld[1];
      b.c1_x     = c_x[1];
      yv = 1'b0;
      yd = '0;
      if (iq.size() > 0 && iq[0].t == cyc) begin
         yv = 1'b1;
         yd = 16'(ref_sqrt(iq[0].x));
      end else if (spur) begin
         yv = 1'b1;
         yd = 16'($urandom);
      end
      b.isqrt_y_vld = yv;
      b.isqrt_y     = yd;
      @(negedge clk);
      full  = (tagq.size() == DEPTH);
      empty = (tagq.size() == 0);
      g0 = !rst && !full && c_vld[0] && (!c_vld[1] || m_last);
      g1 = !rst && !full && c_vld[1] && (!c_vld[0] || !m_last);
      pop  = !rst && yv && !empty;
      head = empty ? 1'b0 : tagq[0];
      ev0 = pop && !head;
      ev1 = pop && head;
      ex = '0;
      if (g0) ex = c_x[0];
      if (g1) ex = c_x[1];
      cap_rdy[0] = b.c0_x_rdy;
      cap_rdy[1] = b.c1_x_rdy;
      cap_yv[0]  = b.c0_y_vld;
      cap_yv[1]  = b.c1_y_vld;
      cap_xv     = b.isqrt_x_vld;
      cap_x      = b.isqrt_x;
      cap_if     = int'(in_flight);
      cap_err    = err;
      chk("c0_x_rdy", b.c0_x_rdy, g0);
      chk("c1_x_rdy", b.c1_x_rdy, g1);
      chk("isqrt_x_vld", b.isqrt_x_vld, g0 || g1);
      chk("isqrt_x", b.isqrt_x, ex);
      chk("c0_y_vld", b.c0_y_vld, ev0);
      chk("c1_y_vld", b.c1_y_vld, ev1);
      chk("c0_y", b.c0_y, ev0 ? qget(eq0, 0) : 0);
      chk("c1_y", b.c1_y, ev1 ? qget(eq1, 0) : 0);
      chk("in_flight", in_flight, rst ? 0 : tagq.size());
      chk("err", err, rst ? 1'b0 : m_err);
      if (b.c0_x_rdy) gnt_log.push_back(0);
      if (b.c1_x_rdy) gnt_log.push_back(1);
      if (b.c0_y_vld) begin
         res_id.push_back(0);
         res_y.push_back(int'(b.c0_y));
      end
      if (b.c1_y_vld) begin
         res_id.push_back(1);
         res_y.push_back(int'(b.c1_y));
      end
      if (rst) begin
         tagq.delete();
         eq0.delete();
         eq1.delete();
         iq.delete();
         m_last = 1'b1;
         m_err  = 1'b0;
         c_vld  = '{0, 0};
      end else begin
         if (iq.size() > 0 && iq[0].t == cyc) void'(iq.pop_front());
         if (pop) begin
            if (head) void'(eq1.pop_front());
            else void'(eq0.pop_front());
            void'(tagq.pop_front());
         end
         if (yv && empty) m_err = 1'b1;
         if (g0 || g1) begin
            pend_t p;
            id = g1 ? 1 : 0;
            tagq.push_back(g1);
            if (g1) eq1.push_back(ref_sqrt(c_x[1]));
            else eq0.push_back(ref_sqrt(c_x[0]));
            p.t = cyc + lat;
            p.x = c_x[id];
            iq.push_back(p);
            m_last = g1;
            c_vld[id] = 1'b0;
         end
         for (int i = 0; i < 2; i++) begin
            if (!c_vld[i] && prob[i] > 0 &&
                int'($urandom_range(99)) < prob[i]) begin
               c_vld[i] = 1'b1;
               c_x[i] = $urandom_range(3) == 0 ?
                        32'($urandom_range(1000)) : $urandom;
            end
         end
      end
      spur = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      int k;
      prob = '{0, 0};
      k = 0;
      while (k < 300 && (tagq.size() > 0 || c_vld[0] || c_vld[1])) begin
         step();
         k++;
      end
      chk("drain_left", tagq.size() + int'(c_vld[0]) + int'(c_vld[1]), 0);
   endtask

   task automatic do_reset();
      c_vld = '{0, 0};
      prob  = '{0, 0};
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic clr_logs();
      gnt_log.delete();
      res_id.delete();
      res_y.delete();
   endtask

   initial begin
      b.c0_x_vld = 1'b0;
      b.c0_x = '0;
      b.c1_x_vld = 1'b0;
      b.c1_x = '0;
      b.isqrt_y_vld = 1'b0;
      b.isqrt_y = '0;
      c_vld = '{0, 0};
      c_x = '{0, 0};
      prob = '{0, 0};

      do_reset();
      chk("rst_in_flight", cap_if, 0);
      chk("rst_err", cap_err, 0);
      chk("rst_rdy0", cap_rdy[0], 0);

      lat = 3;
      clr_logs();
      c_vld[0] = 1'b1;
      c_x[0] = 32'd144;
      step();
      chk("single_rdy", cap_rdy[0], 1);
      chk("single_xv", cap_xv, 1);
      chk("single_x", cap_x, 144);
      drain();
      chk("single_nres", res_id.size(), 1);
      chk("single_id", qget(res_id, 0), 0);
      chk("single_y", qget(res_y, 0), 12);

      do_reset();
      clr_logs();
      c_vld = '{1, 1};
      c_x[0] = 32'd16;
      c_x[1] = 32'd81;
      step();
      step();
      drain();
      chk("tie_g0", qget(gnt_log, 0), 0);
      chk("tie_g1", qget(gnt_log, 1), 1);
      chk("tie_r0_id", qget(res_id, 0), 0);
      chk("tie_r0_y", qget(res_y, 0), 4);
      chk("tie_r1_id", qget(res_id, 1), 1);
      chk("tie_r1_y", qget(res_y, 1), 9);

      clr_logs();
      prob = '{100, 100};
      c_vld = '{1, 1};
      c_x[0] = $urandom;
      c_x[1] = $urandom;
      repeat (20) step();
      drain();
      chk("alt_count", gnt_log.size() >= 20, 1);
      for (int i = 0; i < 20; i++) chk("alt_grant", qget(gnt_log, i), i % 2);
      for (int i = 0; i < gnt_log.size(); i++)
         chk("alt_route", qget(res_id, i), gnt_log[i]);

      lat = 12;
      clr_logs();
      prob[0] = 100;
      c_vld[0] = 1'b1;
      c_x[0] = $urandom;
      for (int s = 0; s < 14; s++) begin
         step();
         rdy_hist[s] = cap_rdy[0];
         if (s == 11) chk("full_if", cap_if, 8);
         if (s == 12) begin
            chk("full_pop_if", cap_if, 8);
            chk("full_pop_yv", cap_yv[0], 1);
         end
      end
      for (int s = 0; s < 14; s++)
         chk("full_rdy", rdy_hist[s], (s < 8 || s == 13) ? 1 : 0);
      drain();
      lat = 3;

      spur = 1'b1;
      step();
      chk("spur_yv0", cap_yv[0], 0);
      chk("spur_yv1", cap_yv[1], 0);
      step();
      chk("spur_err", cap_err, 1);
      repeat (5) step();
      chk("spur_hold", cap_err, 1);
      do_reset();
      chk("spur_rst", cap_err, 0);
      step();
      chk("spur_after", cap_err, 0);

      lat = 12;
      prob[0] = 100;
      c_vld[0] = 1'b1;
      c_x[0] = $urandom;
      repeat (5) step();
      prob[0] = 0;
      c_vld[0] = 1'b0;
      step();
      chk("mid_if5", cap_if, 5);
      do_reset();
      chk("mid_rst_if", cap_if, 0);
      chk("mid_rst_err", cap_err, 0);
      c_vld = '{1, 1};
      c_x[0] = $urandom;
      c_x[1] = $urandom;
      step();
      chk("mid_tie_c0", cap_rdy[0], 1);
      chk("mid_tie_c1", cap_rdy[1], 0);
      drain();

      for (int seg = 0; seg < 6; seg++) begin
         lat = $urandom_range(1, 10);
         prob[0] = $urandom_range(10, 100);
         prob[1] = $urandom_range(10, 100);
         for (int k = 0; k < 150; k++) begin
            if (iq.size() == 0 && $urandom_range(49) == 0) spur = 1'b1;
            step();
         end
         drain();
         do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/isqrt_arb_2.md
ISQRT_ARB_2 -- requirements
Module: isqrt_arb_2

Interface
REQ-001 Parameter DEPTH, default 8, maximum number of requests in flight inside the shared isqrt unit; power of two, 2..64.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 c0_x_vld  input  1  client 0 request valid.
REQ-005 c0_x  input  32  client 0 radicand.
REQ-006 c0_x_rdy  output  1  client 0 request accepted this cycle.
REQ-007 c0_y_vld  output  1  client 0 result valid, one-cycle pulse, no backpressure.
REQ-008 c0_y  output  16  client 0 result.
REQ-009 c1_x_vld, c1_x, c1_x_rdy, c1_y_vld, c1_y: same as REQ-004..008 for client 1.
REQ-010 isqrt_x_vld  output  1  request to shared isqrt.
REQ-011 isqrt_x  output  32  radicand to shared isqrt.
REQ-012 isqrt_y_vld  input  1  shared isqrt result valid.
REQ-013 isqrt_y  input  16  shared isqrt result.
REQ-014 in_flight  output  $clog2(DEPTH)+1  count of issued, not yet returned requests.
REQ-015 err  output  1  sticky: isqrt_y_vld seen with in_flight == 0.

Function
REQ-016 Shared isqrt is in-order, fixed-latency, accepts one request per cycle, has no backpressure; the arbiter SHALL rely on order only, not on latency value.
REQ-017 Request handshake: transfer when cN_x_vld && cN_x_rdy; client holds cN_x_vld and cN_x stable until transfer.
REQ-018 full = (in_flight == DEPTH); when full, both cN_x_rdy SHALL be 0, even if isqrt_y_vld is 1 that cycle.
REQ-019 Arbitration, combinational, when not full: only c0 valid -> grant c0; only c1 valid -> grant c1; both valid -> grant client not granted last (round-robin); at most one rdy high per cycle.
REQ-020 Register last_grant updates only on a transfer; reset value 1 (so c0 wins first tie).
REQ-021 Issue is zero-latency: on a transfer, isqrt_x_vld = 1 and isqrt_x = granted client's x in the same cycle; else isqrt_x_vld = 0, isqrt_x = 0.
REQ-022 Tag FIFO, DEPTH entries of 1 bit (client id): push granted id on transfer; pop on isqrt_y_vld when not empty.
REQ-023 Result routing: on isqrt_y_vld with FIFO non-empty, pulse c{head}_y_vld in the same cycle with c{head}_y = isqrt_y; other client's y_vld = 0.
REQ-024 cN_y SHALL be 0 whenever cN_y_vld = 0.
REQ-025 in_flight: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (allowed only when not full, per REQ-018).
REQ-026 FIFO pointers wrap modulo DEPTH.
REQ-027 isqrt_y_vld with FIFO empty: no pop, no client pulse, err set to 1 next cycle and held until reset.

Reset
REQ-028 While rst: in_flight = 0, FIFO pointers = 0, last_grant = 1, err = 0; all rdy, vld outputs 0 during and in the cycle after reset release only if no request is valid.
REQ-029 Reset mid-operation discards all in-flight tags; isqrt results returning after reset SHALL set err (bench must reset isqrt together with arbiter).

Verification
REQ-030 Single request: c0 x=144 for one cycle -> c0_x_rdy=1, isqrt_x_vld=1, isqrt_x=144 same cycle; later c0_y_vld pulse with c0_y=12, c1_y_vld stays 0.
REQ-031 Tie: c0 x=16 and c1 x=81 held from cycle 0 -> cycle 0 grants c0, cycle 1 grants c1; c0_y=4 returned before c1_y=9.
REQ-032 Sustained contention: both clients valid every cycle for 20 cycles -> grants strictly alternate c0,c1,...; every result routed to its issuer in order.
REQ-033 Full: isqrt latency > DEPTH, DEPTH=8, c0 streaming -> exactly 8 transfers, rdy low with in_flight=8 until first result pops; then one issue next cycle.
REQ-034 Spurious result: isqrt_y_vld=1 with in_flight=0 -> no cN_y_vld, err=1 next cycle, stays 1 until rst.
REQ-035 Reset mid-stream: rst with in_flight=5 -> in_flight=0, err=0, last_grant=1; next tie grants c0.
